// File: rtl/sti_sched.sv
// sti_sched: two-requester round-robin frame scheduler feeding a serializer.
// A granted frame is latched onto pi_*, a one-cycle load pulse starts the
// serializer, its so_valid burst is counted against the frame length, and a
// guard interval separates frames. A frame marked "last" ends the job: the
// scheduler stops granting, waits for the downstream memory to finish and
// parks in DONE until reset.
module sti_sched #(
   parameter int GAP = 4,   // idle guard cycles after each frame (1..15)
   parameter int TMO = 15   // cycles allowed from load to so_valid (1..63)
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  req,
   input  logic [15:0] r0_data,
   input  logic [15:0] r1_data,
   input  logic [4:0]  r0_cfg,
   input  logic [4:0]  r1_cfg,
   input  logic        r0_last,
   input  logic        r1_last,
   output logic [1:0]  gnt,
   output logic        load,
   output logic [15:0] pi_data,
   output logic [1:0]  pi_length,
   output logic        pi_fill,
   output logic        pi_msb,
   output logic        pi_low,
   output logic        pi_end,
   input  logic        so_valid,
   input  logic        oem_finish,
   output logic        busy,
   output logic        done,
   output logic        err
);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      WAIT_V,
      XFER,
      GUARD,
      FLUSH,
      DONE
   } state_t;

   localparam logic [3:0] GAP_C = 4'(GAP);
   localparam logic [5:0] TMO_C = 6'(TMO);

   state_t     state;
   logic       ptr;         // 0: requester 0 wins a tie, 1: requester 1 wins
   logic       end_latch;   // job's final frame has been granted
   logic [5:0] wait_cnt;    // cycles spent in WAIT_V
   logic [5:0] bit_cnt;     // so_valid cycles seen for the current frame
   logic [3:0] gap_cnt;     // guard cycles elapsed, counting from 1

   logic       win;         // arbitration winner (0 or 1)
   logic       grant_ok;
   logic       gap_done;
   logic       take_grant;
   logic [5:0] bit_target;

   // Arbitration: a sole requester always wins, a tie goes to the pointer.
   always_comb begin
      // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
      win = 1'b0;
      case (req)
         2'b10:   win = 1'b1;
         2'b11:   win = ptr;
         default: win = 1'b0;
      endcase
   end

   assign grant_ok = (req != 2'b00) && !end_latch;

   // The last guard cycle doubles as the arbitration slot, so a waiting
   // request is granted GAP+1 cycles after so_valid falls without an extra
   // pass through IDLE.
   assign gap_done   = (state == GUARD) && (gap_cnt == GAP_C);
   assign take_grant = grant_ok && ((state == IDLE) || gap_done);

   // Expected serializer bit count: 8, 16, 24 or 32 bits.
   assign bit_target = {1'b0, pi_length, 3'b000} + 6'd8;

   // Sequencer: state, counters, latches and every registered output.
   always_ff @(posedge clk) begin
      if (!reset) begin
         // NOTE: reset is sampled only at the clock edge, so it sits inside the clocked branch, not in the sensitivity list.
         state     <= IDLE;
         ptr       <= 1'b0;
         end_latch <= 1'b0;
         wait_cnt  <= '0;
         bit_cnt   <= '0;
         gap_cnt   <= '0;
         gnt       <= 2'b00;
         load      <= 1'b0;
         pi_data   <= '0;
         pi_length <= '0;
         pi_fill   <= 1'b0;
         pi_msb    <= 1'b0;
         pi_low    <= 1'b0;
         pi_end    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every branch sees the pre-edge register values.
         gnt  <= 2'b00;
         load <= 1'b0;

         if (take_grant) begin
            gnt       <= win ? 2'b10 : 2'b01;
            pi_data   <= win ? r1_data : r0_data;
            {pi_length, pi_fill, pi_msb, pi_low} <= win ? r1_cfg : r0_cfg;
            pi_end    <= win ? r1_last : r0_last;
            end_latch <= win ? r1_last : r0_last;
            ptr       <= ~ptr;
            busy      <= 1'b1;
            state     <= LOAD;
         end else begin
            case (state)
               IDLE: begin
                  // waiting for a request; granting is handled above
               end

               LOAD: begin
                  load     <= 1'b1;
                  wait_cnt <= '0;
                  state    <= WAIT_V;
               end

               WAIT_V: begin
                  if (so_valid) begin
                     // the first shifted bit is counted on the way in
                     bit_cnt <= 6'd1;
                     state   <= XFER;
                  end else if (wait_cnt + 6'd1 == TMO_C) begin
                     err     <= 1'b1;
                     gap_cnt <= 4'd1;
                     state   <= GUARD;
                  end else begin
                     wait_cnt <= wait_cnt + 6'd1;
                  end
               end

               XFER: begin
                  if (so_valid) begin
                     // saturate so an overlong burst cannot wrap onto a legal length
                     if (bit_cnt != 6'h3f) begin
                        bit_cnt <= bit_cnt + 6'd1;
                     end
                  end else begin
                     if (bit_cnt != bit_target) begin
                        err <= 1'b1;
                     end
                     gap_cnt <= 4'd1;
                     state   <= GUARD;
                  end
               end

               GUARD: begin
                  if (gap_done) begin
                     busy  <= 1'b0;
                     state <= end_latch ? FLUSH : IDLE;
                  end else begin
                     gap_cnt <= gap_cnt + 4'd1;
                  end
               end

               FLUSH: begin
                  if (oem_finish) begin
                     done  <= 1'b1;
                     state <= DONE;
                  end
               end

               DONE: begin
                  // terminal until reset
               end

               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sti_sched.sv
// Testbench for sti_sched: directed scenarios plus a randomized frame stream
// checked against a frame-level model (round-robin pointer, bit-count rule,
// timeout rule, sticky error). All stimulus and sampling happen on the
// falling edge, away from the active rising edge.
module tb_sti_sched;

   localparam int GAP = 4;
   localparam int TMO = 15;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  req;
   logic [15:0] r0_data, r1_data;
   logic [4:0]  r0_cfg, r1_cfg;
   logic        r0_last, r1_last;
   logic [1:0]  gnt;
   logic        load;
   logic [15:0] pi_data;
   logic [1:0]  pi_length;
   logic        pi_fill, pi_msb, pi_low, pi_end;
   logic        so_valid, oem_finish;
   logic        busy, done, err;

   int checks = 0;
   int errors = 0;

   // model state
   bit m_ptr;
   bit m_err;

   always #5 clk = ~clk;

   sti_sched #(.GAP(GAP), .TMO(TMO)) dut (
      .clk        (clk),
      .reset      (reset),
      .req        (req),
      .r0_data    (r0_data),
      .r1_data    (r1_data),
      .r0_cfg     (r0_cfg),
      .r1_cfg     (r1_cfg),
      .r0_last    (r0_last),
      .r1_last    (r1_last),
      .gnt        (gnt),
      .load       (load),
      .pi_data    (pi_data),
      .pi_length  (pi_length),
      .pi_fill    (pi_fill),
      .pi_msb     (pi_msb),
      .pi_low     (pi_low),
      .pi_end     (pi_end),
      .so_valid   (so_valid),
      .oem_finish (oem_finish),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   // ---------------- model helpers ----------------
   function automatic int frame_bits(input logic [4:0] cfg);
      return 8 * (int'(cfg[4:3]) + 1);
   endfunction

   function automatic int pick(input logic [1:0] r, input bit p);
      if (r == 2'b11) return int'(p);
      return r[1] ? 1 : 0;
   endfunction

   function automatic logic [1:0] onehot(input int w);
      return (w == 1) ? 2'b10 : 2'b01;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic apply_reset();
      reset = 1'b0; req = 2'b00; so_valid = 1'b0; oem_finish = 1'b0;
      r0_last = 1'b0; r1_last = 1'b0;
      tick(2);
      reset = 1'b1;
      m_ptr = 1'b0;
      m_err = 1'b0;
   endtask

   // Returns the first non-zero gnt (or 0 after the bound) and cycles waited.
   task automatic wait_gnt(output logic [1:0] g, output int n);
      g = 2'b00;
      n = 0;
      while (n < 200) begin
         tick(1);
         n++;
         if (gnt !== 2'b00) begin
            g = gnt;
            break;
         end
      end
   endtask

   // From the grant cycle: step into the load cycle, idle d cycles, then
   // hold so_valid for n cycles. Ends on the cycle so_valid drops.
   task automatic xfer(input int d, input int n, output logic ld);
      tick(1);
      ld = load;
      tick(d);
      so_valid = 1'b1;
      tick(n);
      so_valid = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1'b0; req = 2'b11; so_valid = 1'b1; oem_finish = 1'b1;
      r0_data = 16'hffff; r1_data = 16'hffff; r0_cfg = 5'h1f; r1_cfg = 5'h1f;
      r0_last = 1'b1; r1_last = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick(1);
         checks++;
         if ({gnt, load, busy, done, err} !== 6'b0 ||
             {pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end} !== 22'b0) begin
            errors++;
            $display("FAIL reset_outputs cycle %0d: gnt=%b load=%b busy=%b done=%b err=%b pi_data=%h, required all zero",
                     i, gnt, load, busy, done, err, pi_data);
         end
      end
      req = 2'b00; so_valid = 1'b0; oem_finish = 1'b0; r0_last = 1'b0; r1_last = 1'b0;
      reset = 1'b1; m_ptr = 1'b0; m_err = 1'b0;
      tick(2);
      checks++;
      if (gnt !== 2'b00 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_release_idle: gnt=%b busy=%b, required 00/0", gnt, busy);
      end
   endtask

   task automatic test_single_frame();
      logic [1:0]  g;
      int          n;
      logic [15:0] dat;
      bit          bad;
      apply_reset();
      dat = 16'($urandom);
      r0_data = dat; r0_cfg = {2'b01, 3'($urandom)}; r0_last = 1'b1;
      r1_data = 16'($urandom); r1_cfg = 5'($urandom); r1_last = 1'b0;
      req = 2'b01;
      oem_finish = 1'b1;   // must be ignored until FLUSH
      wait_gnt(g, n);
      checks++;
      if (g !== 2'b01) begin
         errors++; $display("FAIL single_gnt: got %b required 01", g);
      end
      checks++;
      if ({pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end} !== {dat, r0_cfg, 1'b1}) begin
         errors++;
         $display("FAIL single_pi_fields: got %h/%b%b%b%b/%b required %h/%b/1",
                  pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end, dat, r0_cfg);
      end
      checks++;
      if (busy !== 1'b1 || load !== 1'b0) begin
         errors++; $display("FAIL single_grant_cycle: busy=%b load=%b required 1/0", busy, load);
      end
      req = 2'b00; m_ptr = ~m_ptr;
      tick(1);
      checks++;
      if (load !== 1'b1) begin
         errors++; $display("FAIL single_load_rise: load=%b required 1 one cycle after gnt", load);
      end
      tick(1);
      checks++;
      if (load !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL single_load_pulse: load=%b busy=%b required 0/1", load, busy);
      end
      so_valid = 1'b1; tick(16); so_valid = 1'b0;
      bad = 1'b0;
      for (int i = 0; i < GAP; i++) begin
         tick(1);
         if (busy !== 1'b1 || gnt !== 2'b00) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         errors++; $display("FAIL single_guard_length: busy dropped or gnt seen within %0d guard cycles", GAP);
      end
      oem_finish = 1'b0;
      tick(1);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
         errors++; $display("FAIL single_flush_entry: busy=%b done=%b err=%b required 0/0/0", busy, done, err);
      end
      tick(5);
      checks++;
      if (done !== 1'b0) begin
         errors++; $display("FAIL single_flush_wait: done=%b required 0 before oem_finish", done);
      end
      oem_finish = 1'b1;
      tick(1);
      checks++;
      if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL single_done: done=%b err=%b busy=%b required 1/0/0", done, err, busy);
      end
      oem_finish = 1'b0; req = 2'b11;
      bad = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         if (gnt !== 2'b00 || done !== 1'b1) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         errors++; $display("FAIL single_done_terminal: gnt issued or done dropped after DONE");
      end
      req = 2'b00;
   endtask

   task automatic test_contention();
      logic [1:0]  g;
      int          n, w;
      logic        ld;
      logic [15:0] a, b;
      apply_reset();
      a = 16'($urandom);
      b = a ^ 16'h5a5a;
      r0_data = a; r1_data = b;
      r0_cfg = {2'b00, 3'($urandom)}; r1_cfg = {2'b00, 3'($urandom)};
      req = 2'b11;
      for (int i = 0; i < 4; i++) begin
         wait_gnt(g, n);
         w = pick(req, m_ptr); m_ptr = ~m_ptr;
         checks++;
         if (g !== onehot(w)) begin
            errors++; $display("FAIL contention_gnt #%0d: got %b required %b", i, g, onehot(w));
         end
         checks++;
         if (pi_data !== ((w == 1) ? b : a)) begin
            errors++; $display("FAIL contention_data #%0d: got %h required %h", i, pi_data, (w == 1) ? b : a);
         end
         if (i > 0) begin
            checks++;
            if (n !== GAP + 1) begin
               errors++; $display("FAIL contention_latency #%0d: so_valid fall to gnt %0d cycles, required %0d", i, n, GAP + 1);
            end
         end
         xfer(0, 8, ld);
      end
      tick(1);
      checks++;
      if (err !== 1'b0) begin
         errors++; $display("FAIL contention_err: err=%b required 0", err);
      end
      req = 2'b00;
   endtask

   task automatic test_length_mismatch();
      logic [1:0] g;
      int         n;
      logic       ld;
      int         lens [3] = '{3, 0, 0};
      int         nbits[3] = '{32, 9, 8};
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         r0_cfg = {2'(lens[i]), 3'($urandom)};
         r0_data = 16'($urandom);
         req = 2'b01;
         wait_gnt(g, n);
         req = 2'b00; m_ptr = ~m_ptr;
         checks++;
         if (g !== 2'b01) begin
            errors++; $display("FAIL length_gnt #%0d: got %b required 01", i, g);
         end
         xfer(2, nbits[i], ld);
         checks++;
         if (err !== m_err) begin
            errors++; $display("FAIL length_err_early #%0d: err=%b required %b", i, err, m_err);
         end
         tick(1);
         if (nbits[i] != frame_bits(r0_cfg)) m_err = 1'b1;
         checks++;
         if (err !== m_err) begin
            errors++; $display("FAIL length_err #%0d: err=%b required %b", i, err, m_err);
         end
         tick(GAP);
         checks++;
         if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL length_back_to_idle #%0d: busy=%b done=%b required 0/0", i, busy, done);
         end
      end
   endtask

   task automatic test_timeout();
      logic [1:0] g;
      int         n;
      logic       ld;
      apply_reset();
      // boundary: so_valid on the last allowed WAIT_V cycle is not a timeout
      r0_cfg = {2'b00, 3'($urandom)};
      req = 2'b01;
      wait_gnt(g, n);
      req = 2'b00; m_ptr = ~m_ptr;
      xfer(TMO - 1, 8, ld);
      tick(1);
      checks++;
      if (err !== 1'b0) begin
         errors++; $display("FAIL timeout_boundary: err=%b required 0 with so_valid after %0d cycles", err, TMO - 1);
      end
      tick(GAP);
      // no so_valid at all
      req = 2'b01;
      wait_gnt(g, n);
      req = 2'b00; m_ptr = ~m_ptr;
      tick(1);
      checks++;
      if (load !== 1'b1) begin
         errors++; $display("FAIL timeout_load: load=%b required 1", load);
      end
      tick(TMO - 1);
      checks++;
      if (err !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL timeout_early: err=%b busy=%b required 0/1 at %0d cycles", err, busy, TMO - 1);
      end
      tick(1);
      checks++;
      if (err !== 1'b1 || busy !== 1'b1) begin
         errors++; $display("FAIL timeout_err: err=%b busy=%b required 1/1 at %0d cycles", err, busy, TMO);
      end
      tick(GAP - 1);
      checks++;
      if (busy !== 1'b1) begin
         errors++; $display("FAIL timeout_guard: busy=%b required 1 on last guard cycle", busy);
      end
      tick(1);
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL timeout_idle: busy=%b required 0 after guard", busy);
      end
      req = 2'b01;
      wait_gnt(g, n);
      req = 2'b00;
      checks++;
      if (g !== 2'b01 || err !== 1'b1) begin
         errors++; $display("FAIL timeout_continue: gnt=%b err=%b required 01/1", g, err);
      end
   endtask

   task automatic test_end_latch();
      logic [1:0] g;
      int         n;
      logic       ld;
      bit         seen;
      apply_reset();
      r1_cfg = {2'b10, 3'($urandom)}; r1_last = 1'b1; r1_data = 16'($urandom);
      r0_last = 1'b0;
      req = 2'b10;
      wait_gnt(g, n);
      checks++;
      if (g !== 2'b10 || pi_end !== 1'b1) begin
         errors++; $display("FAIL end_gnt: gnt=%b pi_end=%b required 10/1", g, pi_end);
      end
      req = 2'b01;
      xfer(0, 24, ld);
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         tick(1);
         if (gnt !== 2'b00) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         errors++; $display("FAIL end_no_gnt: gnt issued after the last frame");
      end
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
         errors++; $display("FAIL end_flush: busy=%b done=%b err=%b required 0/0/0", busy, done, err);
      end
      oem_finish = 1'b1;
      tick(1);
      checks++;
      if (done !== 1'b1) begin
         errors++; $display("FAIL end_done: done=%b required 1", done);
      end
      oem_finish = 1'b0; req = 2'b00; r1_last = 1'b0;
   endtask

   task automatic test_mid_frame_reset();
      logic [1:0] g;
      int         n, w;
      logic       ld;
      apply_reset();
      r0_cfg = {2'b00, 3'($urandom)}; r0_last = 1'b0;
      // three grants leave the pointer favouring requester 1; the first sets err
      for (int i = 0; i < 3; i++) begin
         req = 2'b01;
         wait_gnt(g, n);
         req = 2'b00; m_ptr = ~m_ptr;
         if (i < 2) begin
            xfer(0, (i == 0) ? 5 : 8, ld);
            tick(1);
         end
      end
      tick(1);
      so_valid = 1'b1;
      tick(3);
      checks++;
      if (busy !== 1'b1 || err !== 1'b1) begin
         errors++; $display("FAIL midreset_pre: busy=%b err=%b required 1/1 before reset", busy, err);
      end
      reset = 1'b0; req = 2'b11;
      tick(1);
      checks++;
      if ({gnt, load, busy, done, err} !== 6'b0) begin
         errors++; $display("FAIL midreset_outputs: gnt=%b load=%b busy=%b done=%b err=%b required all 0",
                            gnt, load, busy, done, err);
      end
      so_valid = 1'b0; reset = 1'b1;
      m_ptr = 1'b0; m_err = 1'b0;
      wait_gnt(g, n);
      w = pick(2'b11, m_ptr);
      checks++;
      if (g !== onehot(w)) begin
         errors++; $display("FAIL midreset_pointer: gnt=%b required %b", g, onehot(w));
      end
      req = 2'b00;
   endtask

   task automatic test_random();
      logic [1:0]  g, r;
      int          n, w, d, nb, bits;
      logic        ld;
      logic [15:0] d0, d1;
      logic [4:0]  c0, c1, cfg;
      bit          first;
      apply_reset();
      first = 1'b1;
      for (int f = 0; f < 40; f++) begin
         r  = 2'($urandom_range(1, 3));
         d0 = 16'($urandom); d1 = 16'($urandom);
         c0 = 5'($urandom);  c1 = 5'($urandom);
         r0_data = d0; r1_data = d1; r0_cfg = c0; r1_cfg = c1;
         r0_last = 1'b0; r1_last = 1'b0;
         req = r;
         wait_gnt(g, n);
         w = pick(r, m_ptr); m_ptr = ~m_ptr;
         cfg = (w == 1) ? c1 : c0;
         checks++;
         if (g !== onehot(w)) begin
            errors++; $display("FAIL random_gnt frame %0d: got %b required %b (req %b)", f, g, onehot(w), r);
         end
         checks++;
         if ({pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end} !== {((w == 1) ? d1 : d0), cfg, 1'b0}) begin
            errors++; $display("FAIL random_pi frame %0d: got %h/%b%b%b%b required %h/%b",
                               f, pi_data, pi_length, pi_fill, pi_msb, pi_low, (w == 1) ? d1 : d0, cfg);
         end
         if (!first) begin
            checks++;
            if (n !== GAP) begin
               errors++; $display("FAIL random_gap frame %0d: waited %0d cycles, required %0d", f, n, GAP);
            end
         end
         first = 1'b0;
         req = 2'b00;
         d = ($urandom_range(0, 4) == 0) ? TMO + int'($urandom_range(0, 3)) : int'($urandom_range(0, TMO - 1));
         if (d >= TMO) begin
            tick(1);
            ld = load;
            tick(TMO);
            m_err = 1'b1;
         end else begin
            bits = frame_bits(cfg);
            nb = ($urandom_range(0, 2) == 0) ? bits + int'($urandom_range(0, 4)) - 2 : bits;
            xfer(d, nb, ld);
            tick(1);
            if (nb != bits) m_err = 1'b1;
         end
         checks++;
         if (ld !== 1'b1) begin
            errors++; $display("FAIL random_load frame %0d: load=%b required 1", f, ld);
         end
         checks++;
         if (err !== m_err) begin
            errors++; $display("FAIL random_err frame %0d: err=%b required %b", f, err, m_err);
         end
      end
   endtask

   // Safety net: should never trigger; every wait above is bounded.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; req = 2'b00; so_valid = 1'b0; oem_finish = 1'b0;
      r0_data = '0; r1_data = '0; r0_cfg = '0; r1_cfg = '0;
      r0_last = 1'b0; r1_last = 1'b0;
      test_reset();
      test_single_frame();
      test_contention();
      test_length_mismatch();
      test_timeout();
      test_end_latch();
      test_mid_frame_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
